// File: rtl/gray_codec_pkg.sv
// ============================================================================
// Module      : gray_codec_pkg
// Description : Shared types, chunk sizing and reference Gray/binary functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_codec_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {MODE_B2G = 1'b0, MODE_G2B = 1'b1} codec_mode_e;

  function automatic int chunk_f(input int vec_w, input int stages);
    return (vec_w + stages - 1) / stages;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray_f(input logic [MAX_W-1:0] b, input int w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = b[i];
    end
    return m ^ (m >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin_f(input logic [MAX_W-1:0] g, input int w);
    logic [MAX_W-1:0] r;
    logic             acc;
    r   = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        r[i] = acc;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_codec_stage.sv
// ============================================================================
// Module      : gray_codec_stage
// Description : One pipeline slot: holding register, advance logic and its
//               chunk of the MSB-first prefix XOR for Gray-to-binary beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int VEC_W  = 4,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_valid,
  input  logic             up_mode,
  input  logic [VEC_W-1:0] up_data,
  input  logic             up_xor,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic             mode,
  output logic [VEC_W-1:0] data,
  output logic             run_xor
);

  localparam int CHUNK  = chunk_f(VEC_W, STAGES);
  localparam int HI     = VEC_W - 1 - IDX * CHUNK;
  localparam int LO_RAW = VEC_W - (IDX + 1) * CHUNK;
  localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

  logic [VEC_W-1:0] nxt_data;
  logic             nxt_xor;
  logic             acc;

  // Bits below LO still hold raw Gray code; bits at or above have been resolved.
  always_comb begin
    nxt_data = up_data;
    nxt_xor  = up_xor;
    acc      = up_xor;
    if (codec_mode_e'(up_mode) == MODE_B2G) begin
      if (IDX == 0) nxt_data = up_data ^ (up_data >> 1);
      nxt_xor = 1'b0;
    end else begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          acc         = acc ^ up_data[i];
          nxt_data[i] = acc;
        end
      end
      nxt_xor = acc;
    end
  end

  assign ready = ~valid | down_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid   <= 1'b0;
      mode    <= 1'b0;
      data    <= '0;
      run_xor <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        mode    <= up_mode;
        data    <= nxt_data;
        run_xor <= nxt_xor;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gray_codec_pipe.sv
// ============================================================================
// Module      : gray_codec_pipe
// Description : Pipelined bidirectional Gray-code converter with valid/ready.
//               GRAY_CODEC_ADJ_CHECK_EN adds adj_err_o (Gray adjacency check).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int VEC_W  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             mode_i,
  input  logic [VEC_W-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             mode_o,
  output logic [VEC_W-1:0] data_o
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  ,
  output logic             adj_err_o
`endif
);

  // Index 0 is the input side; index k+1 is the output of slot k.
  logic [STAGES:0]  c_valid;
  logic [STAGES:0]  c_mode;
  logic [STAGES:0]  c_xor;
  logic [STAGES:0]  c_ready;
  logic [VEC_W-1:0] c_data [STAGES+1];
  logic             unused_xor;

  assign c_valid[0]      = in_valid_i;
  assign c_mode[0]       = mode_i;
  assign c_data[0]       = data_i;
  assign c_xor[0]        = 1'b0;
  assign c_ready[STAGES] = out_ready_i;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      gray_codec_stage #(
        .VEC_W  (VEC_W),
        .STAGES (STAGES),
        .IDX    (k)
      ) u_stage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .up_valid   (c_valid[k]),
        .up_mode    (c_mode[k]),
        .up_data    (c_data[k]),
        .up_xor     (c_xor[k]),
        .down_ready (c_ready[k+1]),
        .ready      (c_ready[k]),
        .valid      (c_valid[k+1]),
        .mode       (c_mode[k+1]),
        .data       (c_data[k+1]),
        .run_xor    (c_xor[k+1])
      );
    end
  endgenerate

  assign in_ready_o  = ~rst_i & c_ready[0];
  assign out_valid_o = c_valid[STAGES];
  assign mode_o      = c_mode[STAGES];
  assign data_o      = c_data[STAGES];
  assign unused_xor  = c_xor[STAGES];

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic [VEC_W-1:0] hist;
  logic             hist_vld;
  logic [VEC_W-1:0] diff;
  logic             c_err [STAGES+1];

  // Exactly one differing bit <=> diff nonzero and a power of two.
  assign diff     = hist ^ data_i;
  assign c_err[0] = mode_i & hist_vld &
                    ((diff == '0) | (|(diff & (diff - VEC_W'(1)))));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist     <= '0;
      hist_vld <= 1'b0;
    end else if (in_valid_i & in_ready_o) begin
      if (codec_mode_e'(mode_i) == MODE_G2B) begin
        hist     <= data_i;
        hist_vld <= 1'b1;
      end else begin
        hist_vld <= 1'b0;
      end
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_err
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          c_err[k+1] <= 1'b0;
        end else if (c_ready[k] & c_valid[k]) begin
          c_err[k+1] <= c_err[k];
        end
      end
    end
  endgenerate

  assign adj_err_o = c_valid[STAGES] & c_mode[STAGES] & c_err[STAGES];
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
// ============================================================================
// Module      : tb_gray_codec_pipe
// Description : Scoreboard bench for gray_codec_pipe (4/2 and 8/3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_codec_pipe;
  import gray_codec_pkg::*;

  typedef struct {
    logic       m;
    logic [7:0] d;
    logic       adj;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in_valid, a_mode_i, a_out_ready;
  logic [3:0] a_data_i, a_exp;
  logic       a_in_ready, a_out_valid, a_mode_o;
  logic [3:0] a_data_o;
  logic       b_in_valid, b_mode_i, b_out_ready;
  logic [7:0] b_data_i;
  logic       b_in_ready, b_out_valid, b_mode_o;
  logic [7:0] b_data_o;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic       a_adj, b_adj;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_lat = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, na, nb;
  logic [7:0] a_hd, b_hd;
  logic       a_hv, b_hv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_codec_pipe #(.VEC_W(4), .STAGES(2)) u_dut_a (
    .clk_i (clk), .rst_i (rst),
    .in_valid_i (a_in_valid), .in_ready_o (a_in_ready),
    .mode_i (a_mode_i), .data_i (a_data_i),
    .out_valid_o (a_out_valid), .out_ready_i (a_out_ready),
    .mode_o (a_mode_o), .data_o (a_data_o)
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    , .adj_err_o (a_adj)
`endif
  );

  gray_codec_pipe #(.VEC_W(8), .STAGES(3)) u_dut_b (
    .clk_i (clk), .rst_i (rst),
    .in_valid_i (b_in_valid), .in_ready_o (b_in_ready),
    .mode_i (b_mode_i), .data_i (b_data_i),
    .out_valid_o (b_out_valid), .out_ready_i (b_out_ready),
    .mode_o (b_mode_o), .data_o (b_data_o)
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    , .adj_err_o (b_adj)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Scoreboard A: expected pushed on accept, popped on consume.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      a_hv = 1'b0;
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          check("a_unexpected_beat", {31'd0, a_out_valid}, 32'd0);
        end else begin
          ea = qa.pop_front();
          check("a_data", {28'd0, a_data_o}, {24'd0, ea.d});
          check("a_mode", {31'd0, a_mode_o}, {31'd0, ea.m});
`ifdef GRAY_CODEC_ADJ_CHECK_EN
          check("a_adj", {31'd0, a_adj}, {31'd0, ea.adj});
`endif
          if (chk_lat) check("a_latency", cyc - ea.cyc, 32'd2);
        end
      end
      if (a_in_valid && a_in_ready) begin
        na.m   = a_mode_i;
        na.d   = {4'd0, a_exp};
        na.cyc = cyc;
        na.adj = 1'b0;
        if (a_mode_i) begin
          na.adj = a_hv && ($countones(a_hd ^ {4'd0, a_data_i}) != 1);
          a_hd   = {4'd0, a_data_i};
          a_hv   = 1'b1;
        end else begin
          a_hv = 1'b0;
        end
        qa.push_back(na);
      end
    end
  end

  // Scoreboard B: expected values from the package reference functions.
  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      b_hv = 1'b0;
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          check("b_unexpected_beat", {31'd0, b_out_valid}, 32'd0);
        end else begin
          eb = qb.pop_front();
          check("b_data", {24'd0, b_data_o}, {24'd0, eb.d});
          check("b_mode", {31'd0, b_mode_o}, {31'd0, eb.m});
`ifdef GRAY_CODEC_ADJ_CHECK_EN
          check("b_adj", {31'd0, b_adj}, {31'd0, eb.adj});
`endif
        end
      end
      if (b_in_valid && b_in_ready) begin
        nb.m   = b_mode_i;
        nb.d   = b_mode_i ? 8'(gray2bin_f(64'(b_data_i), 8)) : 8'(bin2gray_f(64'(b_data_i), 8));
        nb.cyc = cyc;
        nb.adj = 1'b0;
        if (b_mode_i) begin
          nb.adj = b_hv && ($countones(b_hd ^ b_data_i) != 1);
          b_hd   = b_data_i;
          b_hv   = 1'b1;
        end else begin
          b_hv = 1'b0;
        end
        qb.push_back(nb);
      end
    end
  end

  task automatic wait_accept_a();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_in_ready) begin
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("a_accept_timeout", {31'd0, a_in_ready}, 32'd1);
    a_in_valid = 1'b0;
  endtask

  task automatic send_a(input logic m, input logic [3:0] d, input logic [3:0] e);
    a_in_valid = 1'b1;
    a_mode_i   = m;
    a_data_i   = d;
    a_exp      = e;
    wait_accept_a();
  endtask

  task automatic send_b(input logic m, input logic [7:0] d);
    b_in_valid = 1'b1;
    b_mode_i   = m;
    b_data_i   = d;
    for (int t = 0; t < 200; t++) begin
      b_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b_in_ready) begin
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("b_accept_timeout", {31'd0, b_in_ready}, 32'd1);
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int t = 0; t < 100 && qa.size() != 0; t++) @(posedge clk);
    #1;
    check("a_drain_left", qa.size(), 32'd0);
  endtask

  task automatic drain_b();
    for (int t = 0; t < 200 && qb.size() != 0; t++) @(posedge clk);
    #1;
    check("b_drain_left", qb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_mode_i = 1'b0; a_data_i = '0; a_exp = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_mode_i = 1'b0; b_data_i = '0; b_out_ready = 1'b1;
    a_hd = '0; a_hv = 1'b0; b_hd = '0; b_hv = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_data", {28'd0, a_data_o}, 32'd0);
    check("rst_mode", {31'd0, a_mode_o}, 32'd0);
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
    check("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk); #1;

    // Mode 0 sweep back-to-back with latency check
    chk_lat = 1'b1;
    for (int x = 0; x < 16; x++) send_a(1'b0, 4'(x), 4'(bin2gray_f(64'(x), 4)));
    send_a(1'b0, 4'b0101, 4'b0111);
    send_a(1'b0, 4'b1111, 4'b1000);
    drain_a();
    chk_lat = 1'b0;

    // Mode 1 directed and round trip
    send_a(1'b1, 4'b0111, 4'b0101);
    send_a(1'b1, 4'b1000, 4'b1111);
    send_a(1'b1, 4'b0000, 4'b0000);
    for (int x = 0; x < 16; x++) send_a(1'b1, 4'(bin2gray_f(64'(x), 4)), 4'(x));
    drain_a();

    // Backpressure: third beat must wait, output holds
    a_out_ready = 1'b0;
    send_a(1'b0, 4'b0001, 4'b0001);
    send_a(1'b0, 4'b0010, 4'b0011);
    a_in_valid = 1'b1; a_mode_i = 1'b0; a_data_i = 4'b0011; a_exp = 4'b0010;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, a_out_valid}, 32'd1);
      check("bp_data_hold", {28'd0, a_data_o}, 32'd1);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    wait_accept_a();
    drain_a();

    // Interleaved modes on the same data
    send_a(1'b0, 4'b0011, 4'b0010);
    send_a(1'b1, 4'b0011, 4'b0010);
    send_a(1'b0, 4'b0011, 4'b0010);
    send_a(1'b1, 4'b0011, 4'b0010);
    drain_a();

    // Adjacency sequence (adj_err_o compared when the feature is built)
    send_a(1'b0, 4'b0000, 4'b0000);
    send_a(1'b1, 4'b0000, 4'b0000);
    send_a(1'b1, 4'b0001, 4'b0001);
    send_a(1'b1, 4'b0011, 4'b0010);
    send_a(1'b1, 4'b0000, 4'b0000);
    send_a(1'b0, 4'b0101, 4'b0111);
    send_a(1'b1, 4'b0110, 4'b0100);
    drain_a();

    // Reset with two beats in flight
    send_a(1'b0, 4'b1010, 4'b1111);
    send_a(1'b1, 4'b1010, 4'b1100);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_flush_out_valid", {31'd0, a_out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("no_stale_beat", {31'd0, a_out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Wide instance: random stream with random backpressure
    for (int n = 0; n < 150; n++) send_b(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    b_out_ready = 1'b1;
    drain_b();
    send_b(1'b0, 8'hFF);
    send_b(1'b1, 8'hFF);
    send_b(1'b1, 8'h00);
    b_out_ready = 1'b1;
    drain_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
